// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the LEGv8 program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        SEQ,
        IMM,
        REG,
        RAS
    } next_src_e;

    localparam int unsigned PC_MAX_WIDTH   = 64;
    localparam int unsigned DEF_INST_BYTES = 4;
    localparam int unsigned ALIGN_BITS     = $clog2(DEF_INST_BYTES);

    // PC-relative target; bits shifted past the top are dropped by the fixed width.
    function automatic logic [PC_MAX_WIDTH-1:0] imm_target(
        input logic [PC_MAX_WIDTH-1:0] pc,
        input logic [PC_MAX_WIDTH-1:0] imm,
        input int unsigned             shift
    );
        return pc + (imm << shift);
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Circular return-address stack: oldest entry is overwritten when full.
module pc_ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d, top_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_eff;

    assign top_idx = sp_q - PTR_W'(1);
    assign empty_o = (count_q == '0);
    assign top_o   = mem_q[top_idx];
    assign pop_eff = pop_i & ~empty_o;

    always_comb begin
        // NOTE: defaults first so every path assigns the next state and no latch is inferred.
        sp_d    = sp_q;
        count_d = count_q;
        if (pop_eff && !push_i) begin
            sp_d    = top_idx;
            count_d = count_q - CNT_W'(1);
        end else if (push_i && !pop_eff) begin
            sp_d = sp_q + PTR_W'(1);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep register updates order-independent.
        if (rst_i) begin
            sp_q    <= '0;
            count_q <= '0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
        end
    end

    // NOTE: entries are not reset; count guards every read of a stale slot.
    always_ff @(posedge clk) begin
        if (!rst_i && push_i) begin
            mem_q[pop_eff ? top_idx : sp_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered LEGv8 program counter with next-PC selection and alignment fault.
// Optional return-address stack enabled by defining PC_SEQUENCER_RAS_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                  PC_WIDTH   = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  INST_BYTES = DEF_INST_BYTES,
    parameter int                  IMM_SHIFT  = 2,
    parameter int                  RAS_DEPTH  = 4
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                FetchReady,
    input  logic                Stall,
    input  logic [PC_WIDTH-1:0] SignExtImm,
    input  logic [PC_WIDTH-1:0] RegTarget,
    input  logic                Branch,
    input  logic                BranchInv,
    input  logic                Uncondbranch,
    input  logic                BranchReg,
    input  logic                Link,
    input  logic                RetHint,
    input  logic                ALUZero,
    output logic [PC_WIDTH-1:0] CurrentPC,
    output logic                PCValid,
    output logic [PC_WIDTH-1:0] NextPC,
    output logic [PC_WIDTH-1:0] LinkAddr,
    output logic                Taken,
    output logic                AlignFault
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INST_BYTES - 1);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                valid_q;
    logic                fault_q, fault_d;
    logic                advance;
    logic [PC_WIDTH-1:0] imm_tgt;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_hit;
    next_src_e           src;

    assign advance  = valid_q & FetchReady & ~Stall;
    assign LinkAddr = pc_q + PC_WIDTH'(INST_BYTES);
    assign imm_tgt  = PC_WIDTH'(imm_target(PC_MAX_WIDTH'(pc_q), PC_MAX_WIDTH'(SignExtImm),
                                           IMM_SHIFT));

`ifdef PC_SEQUENCER_RAS_EN
    logic ras_empty;

    pc_ret_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_ret_stack (
        .clk         (CLK),
        .rst_i       (Reset),
        .push_i      (advance & Link),
        .pop_i       (advance & BranchReg & RetHint),
        .push_data_i (LinkAddr),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );

    assign ras_hit = RetHint & ~ras_empty;
`else
    logic unused_ras_ctrl;

    assign unused_ras_ctrl = RetHint ^ Link;
    assign ras_top         = '0;
    assign ras_hit         = 1'b0;
`endif

    always_comb begin
        src = SEQ;
        if (BranchReg) begin
            src = ras_hit ? RAS : REG;
        end else if (Uncondbranch || (Branch && (ALUZero ^ BranchInv))) begin
            src = IMM;
        end

        unique case (src)
            IMM:     NextPC = imm_tgt;
            REG:     NextPC = RegTarget;
            RAS:     NextPC = ras_top;
            default: NextPC = LinkAddr;
        endcase
        Taken = (src != SEQ);

        // A misaligned target is forced onto the instruction grid and latched as a fault.
        pc_d    = pc_q;
        fault_d = fault_q;
        if (advance) begin
            pc_d = NextPC & ~ALIGN_MASK;
            if ((NextPC & ALIGN_MASK) != '0) begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            fault_q <= fault_d;
        end
    end

    assign CurrentPC  = pc_q;
    assign PCValid    = valid_q;
    assign AlignFault = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed plan plus randomized traffic vs. a reference model.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam int RAS_DEPTH = 4;

    logic        CLK = 1'b0;
    logic        Reset, FetchReady, Stall, Branch, BranchInv, Uncondbranch;
    logic        BranchReg, Link, RetHint, ALUZero;
    logic [63:0] SignExtImm, RegTarget;
    logic [63:0] CurrentPC, NextPC, LinkAddr;
    logic        PCValid, Taken, AlignFault;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: architectural PC, flags and the stack as a plain queue.
    logic [63:0] m_pc;
    bit          m_valid, m_fault, m_known;
    logic [63:0] m_ras [$];

    always #5 CLK = ~CLK;

    pc_sequencer #(
        .PC_WIDTH   (64),
        .RESET_PC   (64'h0),
        .INST_BYTES (4),
        .IMM_SHIFT  (2),
        .RAS_DEPTH  (RAS_DEPTH)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .FetchReady   (FetchReady),
        .Stall        (Stall),
        .SignExtImm   (SignExtImm),
        .RegTarget    (RegTarget),
        .Branch       (Branch),
        .BranchInv    (BranchInv),
        .Uncondbranch (Uncondbranch),
        .BranchReg    (BranchReg),
        .Link         (Link),
        .RetHint      (RetHint),
        .ALUZero      (ALUZero),
        .CurrentPC    (CurrentPC),
        .PCValid      (PCValid),
        .NextPC       (NextPC),
        .LinkAddr     (LinkAddr),
        .Taken        (Taken),
        .AlignFault   (AlignFault)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic idle();
        Reset = 1'b0; FetchReady = 1'b1; Stall = 1'b0;
        Branch = 1'b0; BranchInv = 1'b0; Uncondbranch = 1'b0;
        BranchReg = 1'b0; Link = 1'b0; RetHint = 1'b0; ALUZero = 1'b0;
        SignExtImm = '0; RegTarget = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic tick();
        logic [63:0] tgt;
        bit          taken, pop, adv;
        #1;
        pop   = RAS_ON && BranchReg && RetHint && (m_ras.size() > 0);
        taken = 1'b1;
        if (BranchReg)
            tgt = pop ? m_ras[$] : RegTarget;
        else if (Uncondbranch || (Branch && (ALUZero != BranchInv)))
            tgt = m_pc + SignExtImm * 64'd4;
        else begin
            tgt   = m_pc + 64'd4;
            taken = 1'b0;
        end
        if (m_known) begin
            check("next_pc", NextPC, tgt);
            check("taken", {63'b0, Taken}, {63'b0, taken});
            check("link_addr", LinkAddr, m_pc + 64'd4);
        end
        adv = m_valid && FetchReady && !Stall;
        if (Reset) begin
            m_pc = '0; m_valid = 1'b0; m_fault = 1'b0; m_known = 1'b1;
            m_ras.delete();
        end else begin
            if (adv) begin
                if (tgt[1:0] != 2'b00) m_fault = 1'b1;
                if (RAS_ON) begin
                    if (pop && Link) m_ras[m_ras.size()-1] = m_pc + 64'd4;
                    else if (pop) void'(m_ras.pop_back());
                    else if (Link) begin
                        m_ras.push_back(m_pc + 64'd4);
                        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                    end
                end
                m_pc = {tgt[63:2], 2'b00};
            end
            m_valid = 1'b1;
        end
        @(posedge CLK);
        #1;
        if (m_known) begin
            check("current_pc", CurrentPC, m_pc);
            check("pc_valid", {63'b0, PCValid}, {63'b0, m_valid});
            check("align_fault", {63'b0, AlignFault}, {63'b0, m_fault});
        end
    endtask

    task automatic jump(input logic [63:0] addr);
        idle();
        BranchReg = 1'b1;
        RegTarget = addr;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        tick();
        idle();
        tick();
    endtask

    initial begin
        logic [31:0] r;
        m_known = 1'b0;
        m_pc    = '0;

        // Reset for two cycles, then sequential fetch 0, 4, 8, 12.
        idle();
        Reset = 1'b1;
        tick();
        tick();
        check("reset_valid_low", {63'b0, PCValid}, 64'd0);
        idle();
        tick();
        check("first_pc", CurrentPC, 64'h0);
        tick();
        check("seq_pc_4", CurrentPC, 64'h4);
        tick();
        tick();
        check("seq_pc_12", CurrentPC, 64'hC);

        // CBZ / CBNZ from 0x100 with a backward offset of two instructions.
        jump(64'h100);
        Branch = 1'b1; ALUZero = 1'b1; SignExtImm = -64'sd2;
        tick();
        check("cbz_taken", CurrentPC, 64'hF8);
        jump(64'h100);
        Branch = 1'b1; ALUZero = 1'b0; SignExtImm = -64'sd2;
        tick();
        check("cbz_not_taken", CurrentPC, 64'h104);
        jump(64'h100);
        Branch = 1'b1; BranchInv = 1'b1; ALUZero = 1'b0; SignExtImm = -64'sd2;
        tick();
        check("cbnz_taken", CurrentPC, 64'hF8);

        // Stall holds the PC while control inputs wander, then B +0x10.
        jump(64'h200);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            BranchReg = (i == 1); RegTarget = 64'h777; Uncondbranch = (i != 1);
            tick();
            check("stall_hold", CurrentPC, 64'h200);
        end
        idle();
        Uncondbranch = 1'b1; SignExtImm = 64'h10;
        tick();
        check("branch_after_stall", CurrentPC, 64'h240);

        // FetchReady low also holds.
        idle();
        FetchReady = 1'b0; Uncondbranch = 1'b1; SignExtImm = 64'h8;
        tick();
        check("fetch_not_ready", CurrentPC, 64'h240);

        // Silent wrap-around, then a misaligned register target.
        jump(64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wrap_pc", CurrentPC, 64'h0);
        check("wrap_no_fault", {63'b0, AlignFault}, 64'd0);
        BranchReg = 1'b1; RegTarget = 64'h1006;
        tick();
        check("misaligned_pc", CurrentPC, 64'h1004);
        check("fault_set", {63'b0, AlignFault}, 64'd1);
        idle();
        tick();
        tick();
        check("fault_sticky", {63'b0, AlignFault}, 64'd1);

        // Reset wins over a stall and clears the fault.
        Reset = 1'b1; Stall = 1'b1;
        tick();
        check("reset_clears_fault", {63'b0, AlignFault}, 64'd0);
        check("reset_pc", CurrentPC, 64'h0);
        idle();
        tick();

`ifdef PC_SEQUENCER_RAS_EN
        // BL at 0x40 and 0x80, then three RETs.
        do_reset();
        jump(64'h40);
        Uncondbranch = 1'b1; Link = 1'b1; SignExtImm = 64'h10;
        tick();
        SignExtImm = 64'h20;
        tick();
        idle();
        BranchReg = 1'b1; RetHint = 1'b1; RegTarget = 64'h0;
        tick();
        check("ras_ret1", CurrentPC, 64'h84);
        tick();
        check("ras_ret2", CurrentPC, 64'h44);
        tick();
        check("ras_ret_empty", CurrentPC, 64'h0);

        // Five BLs overflow a four-entry stack.
        do_reset();
        Uncondbranch = 1'b1; Link = 1'b1; SignExtImm = 64'h4;
        for (int i = 0; i < 5; i++) tick();
        idle();
        BranchReg = 1'b1; RetHint = 1'b1; RegTarget = 64'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ras_overflow_ret", CurrentPC, 64'h44 - 64'(i) * 64'h10);
        end
        tick();
        check("ras_overflow_empty", CurrentPC, 64'h0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            Reset        = ($urandom_range(0, 59) == 0);
            FetchReady   = ($urandom_range(0, 3) != 0);
            Stall        = ($urandom_range(0, 3) == 0);
            Branch       = ($urandom_range(0, 2) == 0);
            BranchInv    = ($urandom_range(0, 1) == 1);
            Uncondbranch = ($urandom_range(0, 4) == 0);
            BranchReg    = ($urandom_range(0, 4) == 0);
            Link         = ($urandom_range(0, 2) == 0);
            RetHint      = ($urandom_range(0, 1) == 1);
            ALUZero      = ($urandom_range(0, 1) == 1);
            SignExtImm   = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                                        : {{44{r[19]}}, r[19:0]};
            RegTarget    = {$urandom, $urandom} & ~64'h3;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
